iob_wbuf: RTL and testbench



---
 rtl/iob_wbuf.sv | 173 +++++++++++++++++
 tb/tb_iob_wbuf.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_wbuf.sv
// Posted-write buffer for the data-side IOb bus: zero-latency write accept, in-order drain,
// reads held until the buffer is empty. Define IOB_WBUF_MERGE_EN to merge writes into the tail entry.
module iob_wbuf #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    rst_n_i,
    input  logic                    u_avalid_i,
    input  logic [ADDR_W-1:0]       u_addr_i,
    input  logic [DATA_W-1:0]       u_wdata_i,
    input  logic [DATA_W/8-1:0]     u_wstrb_i,
    output logic [DATA_W-1:0]       u_rdata_o,
    output logic                    u_rvalid_o,
    output logic                    u_ready_o,
    output logic                    d_avalid_o,
    output logic [ADDR_W-1:0]       d_addr_o,
    output logic [DATA_W-1:0]       d_wdata_o,
    output logic [DATA_W/8-1:0]     d_wstrb_o,
    input  logic [DATA_W-1:0]       d_rdata_i,
    input  logic                    d_rvalid_i,
    input  logic                    d_ready_i,
    output logic                    empty_o,
    output logic [DEPTH_LOG2:0]     level_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RD_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, wr_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;

    logic [ADDR_W-1:0]       mem_addr [DEPTH];
    logic [DATA_W-1:0]       mem_data [DEPTH];
    logic [STRB_W-1:0]       mem_strb [DEPTH];

    logic                    is_write;
    logic                    full;
    logic                    merge_hit;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    merge;

    logic                    u_ready_c, u_rvalid_c, d_avalid_c;
    logic [DATA_W-1:0]       u_rdata_c, d_wdata_c;
    logic [ADDR_W-1:0]       d_addr_c;
    logic [STRB_W-1:0]       d_wstrb_c;

    assign is_write = |u_wstrb_i;
    assign full     = (count_q == FULL_CNT);

`ifdef IOB_WBUF_MERGE_EN
    logic [DEPTH_LOG2-1:0]   tail_ptr;
    logic [DATA_W-1:0]       merged_data;

    assign tail_ptr = wr_ptr_q - DEPTH_LOG2'(1);

    // The tail may only be merged while it is not also the head being presented downstream.
    assign merge_hit = (state_q == DRAIN) && is_write
                       && (count_q >= (DEPTH_LOG2 + 1)'(2))
                       && (mem_addr[tail_ptr] == u_addr_i);

    always_comb begin
        merged_data = mem_data[tail_ptr];
        for (int i = 0; i < STRB_W; i++) begin
            if (u_wstrb_i[i]) merged_data[i*8 +: 8] = u_wdata_i[i*8 +: 8];
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        u_ready_c  = 1'b0;
        u_rvalid_c = 1'b0;
        u_rdata_c  = '0;
        d_avalid_c = 1'b0;
        d_addr_c   = '0;
        d_wdata_c  = '0;
        d_wstrb_c  = '0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                // Reads go straight through so an empty buffer adds no read latency.
                u_ready_c  = is_write ? 1'b1 : d_ready_i;
                d_avalid_c = u_avalid_i && !is_write;
                d_addr_c   = u_addr_i;
                d_wdata_c  = u_wdata_i;
                if (u_avalid_i && u_ready_c) state_d = is_write ? DRAIN : RD_WAIT;
            end
            DRAIN: begin
                u_ready_c  = is_write && (merge_hit || !full);
                d_avalid_c = 1'b1;
                d_addr_c   = mem_addr[rd_ptr_q];
                d_wdata_c  = mem_data[rd_ptr_q];
                d_wstrb_c  = mem_strb[rd_ptr_q];
                pop        = d_ready_i;
            end
            RD_WAIT: begin
                u_rdata_c  = d_rdata_i;
                u_rvalid_c = d_rvalid_i;
                if (d_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = u_avalid_i && u_ready_c;
        push   = accept && is_write && !merge_hit;
        merge  = accept && merge_hit;

        if (state_q == DRAIN && pop && count_q == ONE_CNT && !push) state_d = IDLE;
    end

    // Handshake outputs also drop with cke_i so neither side sees a transfer that is not recorded.
    assign u_ready_o  = rst_n_i && cke_i && u_ready_c;
    assign d_avalid_o = rst_n_i && cke_i && d_avalid_c;
    assign u_rvalid_o = rst_n_i && u_rvalid_c;
    assign u_rdata_o  = rst_n_i ? u_rdata_c : '0;
    assign d_addr_o   = rst_n_i ? d_addr_c  : '0;
    assign d_wdata_o  = rst_n_i ? d_wdata_c : '0;
    assign d_wstrb_o  = rst_n_i ? d_wstrb_c : '0;
    assign empty_o    = rst_n_i && (state_q == IDLE);
    assign level_o    = rst_n_i ? count_q : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        end
    end

    // NOTE: entry storage has no reset; count_q and state_q decide whether any entry is observed.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && cke_i) begin
            if (push) begin
                mem_addr[wr_ptr_q] <= u_addr_i;
                mem_data[wr_ptr_q] <= u_wdata_i;
                mem_strb[wr_ptr_q] <= u_wstrb_i;
            end
`ifdef IOB_WBUF_MERGE_EN
            if (merge) begin
                mem_data[tail_ptr] <= merged_data;
                mem_strb[tail_ptr] <= mem_strb[tail_ptr] | u_wstrb_i;
            end
`else
            if (merge) mem_strb[wr_ptr_q] <= u_wstrb_i;
`endif
        end
    end

endmodule

// File: tb/tb_iob_wbuf.sv
// Directed self-checking bench for iob_wbuf; expectations follow IOB_WBUF_MERGE_EN when defined.
module tb_iob_wbuf;

    logic        clk = 1'b0;
    logic        cke;
    logic        rst_n;
    logic        u_avalid;
    logic [31:0] u_addr;
    logic [31:0] u_wdata;
    logic [3:0]  u_wstrb;
    logic [31:0] u_rdata;
    logic        u_rvalid;
    logic        u_ready;
    logic        d_avalid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_ready;
    logic        empty;
    logic [2:0]  level;

    int n_checks = 0;
    int n_errors = 0;

    iob_wbuf #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(2)) dut (
        .clk_i      (clk),
        .cke_i      (cke),
        .rst_n_i    (rst_n),
        .u_avalid_i (u_avalid),
        .u_addr_i   (u_addr),
        .u_wdata_i  (u_wdata),
        .u_wstrb_i  (u_wstrb),
        .u_rdata_o  (u_rdata),
        .u_rvalid_o (u_rvalid),
        .u_ready_o  (u_ready),
        .d_avalid_o (d_avalid),
        .d_addr_o   (d_addr),
        .d_wdata_o  (d_wdata),
        .d_wstrb_o  (d_wstrb),
        .d_rdata_i  (d_rdata),
        .d_rvalid_i (d_rvalid),
        .d_ready_i  (d_ready),
        .empty_o    (empty),
        .level_o    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        u_avalid = 1'b1;
        u_addr   = a;
        u_wdata  = d;
        u_wstrb  = s;
    endtask

    task automatic idle_req();
        u_avalid = 1'b0;
        u_addr   = '0;
        u_wdata  = '0;
        u_wstrb  = '0;
    endtask

`ifdef IOB_WBUF_MERGE_EN
    localparam int N_EXP = 2;
`else
    localparam int N_EXP = 3;
`endif
    logic [31:0] exp_addr [3];
    logic [31:0] exp_data [3];
    logic [3:0]  exp_strb [3];

    initial begin
        exp_addr[0] = 32'h300; exp_data[0] = 32'hDEADBEEF; exp_strb[0] = 4'hF;
`ifdef IOB_WBUF_MERGE_EN
        exp_addr[1] = 32'h400; exp_data[1] = 32'h22221111; exp_strb[1] = 4'hF;
        exp_addr[2] = 32'h0;   exp_data[2] = 32'h0;        exp_strb[2] = 4'h0;
`else
        exp_addr[1] = 32'h400; exp_data[1] = 32'h00001111; exp_strb[1] = 4'h3;
        exp_addr[2] = 32'h400; exp_data[2] = 32'h22220000; exp_strb[2] = 4'hC;
`endif

        rst_n = 1'b0; cke = 1'b1; d_rdata = '0; d_rvalid = 1'b0; d_ready = 1'b1;
        drive(32'h100, 32'hAABBCCDD, 4'hF);
        step(); step();
        check("rst_u_ready", u_ready, 0);
        check("rst_empty", empty, 0);
        check("rst_d_avalid", d_avalid, 0);
        check("rst_level", level, 0);

        idle_req(); d_ready = 1'b0; rst_n = 1'b1;
        #1;
        check("idle_empty", empty, 1);
        check("idle_level", level, 0);
        check("idle_d_avalid", d_avalid, 0);

        // Single write held off downstream for five cycles.
        step();
        drive(32'h100, 32'hAABBCCDD, 4'hF);
        #1;
        check("w0_u_ready", u_ready, 1);
        check("w0_d_avalid_c0", d_avalid, 0);
        step(); idle_req();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("w0_d_avalid", d_avalid, 1);
            check("w0_d_addr", d_addr, 32'h100);
            check("w0_d_wdata", d_wdata, 32'hAABBCCDD);
            check("w0_d_wstrb", d_wstrb, 4'hF);
            step();
        end
        d_ready = 1'b1;
        #1;
        check("w0_level_before_pop", level, 1);
        step(); d_ready = 1'b0;
        #1;
        check("w0_empty", empty, 1);
        check("w0_level", level, 0);

        // Fill to DEPTH, stall the fifth write, then release downstream.
        for (int i = 0; i < 4; i++) begin
            drive(32'h500 + 32'(i * 16), 32'h1000 + 32'(i), 4'hF);
            #1;
            check("fill_u_ready", u_ready, 1);
            step();
        end
        drive(32'h540, 32'h1004, 4'hF);
        #1;
        check("full_u_ready", u_ready, 0);
        check("full_level", level, 4);
        step(); #1;
        check("full_u_ready_hold", u_ready, 0);
        d_ready = 1'b1;
        #1;
        check("full_u_ready_on_pop", u_ready, 0);
        check("full_head_addr", d_addr, 32'h500);
        step(); #1;
        check("after_pop_u_ready", u_ready, 1);
        check("after_pop_level", level, 3);
        check("after_pop_head", d_addr, 32'h510);
        step(); idle_req();
        for (int j = 2; j < 5; j++) begin
            #1;
            check("drain_d_avalid", d_avalid, 1);
            check("drain_d_addr", d_addr, 32'h500 + 32'(j * 16));
            check("drain_d_wdata", d_wdata, 32'h1000 + 32'(j));
            step();
        end
        #1;
        check("drain_empty", empty, 1);
        d_ready = 1'b0;

        // Read behind two buffered writes.
        drive(32'h600, 32'h6, 4'hF); step();
        drive(32'h610, 32'h7, 4'hF); step();
        drive(32'h200, 32'h0, 4'h0);
        #1;
        check("rd_blk_u_ready", u_ready, 0);
        check("rd_blk_level", level, 2);
        d_ready = 1'b1;
        #1;
        check("rd_blk_u_ready_pop1", u_ready, 0);
        step(); #1;
        check("rd_blk_u_ready_pop2", u_ready, 0);
        check("rd_blk_head", d_addr, 32'h610);
        step(); #1;
        check("rd_go_u_ready", u_ready, 1);
        check("rd_go_d_avalid", d_avalid, 1);
        check("rd_go_d_addr", d_addr, 32'h200);
        check("rd_go_d_wstrb", d_wstrb, 0);
        step(); idle_req(); d_ready = 1'b0;
        #1;
        check("rd_wait_rvalid", u_rvalid, 0);
        check("rd_wait_empty", empty, 0);
        check("rd_wait_d_avalid", d_avalid, 0);
        d_rvalid = 1'b1; d_rdata = 32'h12345678;
        #1;
        check("rd_rvalid", u_rvalid, 1);
        check("rd_rdata", u_rdata, 32'h12345678);
        step(); d_rvalid = 1'b0; d_rdata = '0;
        #1;
        check("rd_done_empty", empty, 1);

        // Merge stimulus with downstream stalled.
        drive(32'h300, 32'hDEADBEEF, 4'hF);
        #1; check("mg_u_ready0", u_ready, 1);
        step();
        drive(32'h400, 32'h00001111, 4'h3);
        #1; check("mg_u_ready1", u_ready, 1);
        step();
        drive(32'h400, 32'h22220000, 4'hC);
        #1; check("mg_u_ready2", u_ready, 1);
        step(); idle_req();
        #1;
        check("mg_level", level, 3'(N_EXP));
        d_ready = 1'b1;
        for (int j = 0; j < N_EXP; j++) begin
            #1;
            check("mg_d_avalid", d_avalid, 1);
            check("mg_d_addr", d_addr, exp_addr[j]);
            check("mg_d_wdata", d_wdata, exp_data[j]);
            check("mg_d_wstrb", d_wstrb, exp_strb[j]);
            step();
        end
        #1;
        check("mg_empty", empty, 1);
        d_ready = 1'b0;

        // Reset mid-operation discards a buffered write and an outstanding read.
        drive(32'h700, 32'h77, 4'hF); step(); idle_req();
        #1;
        check("rm_level", level, 1);
        rst_n = 1'b0;
        #1;
        check("rm_forced_d_avalid", d_avalid, 0);
        check("rm_forced_empty", empty, 0);
        step(); rst_n = 1'b1;
        #1;
        check("rm_level_after", level, 0);
        check("rm_empty_after", empty, 1);
        check("rm_d_avalid_after", d_avalid, 0);
        d_ready = 1'b1;
        drive(32'h800, 32'h0, 4'h0);
        step(); idle_req(); d_ready = 1'b0;
        #1;
        check("rm_rd_wait", empty, 0);
        rst_n = 1'b0;
        step(); rst_n = 1'b1;
        d_rvalid = 1'b1; d_rdata = 32'hCAFEF00D;
        #1;
        check("rm_stale_rvalid", u_rvalid, 0);
        check("rm_stale_empty", empty, 1);
        step(); d_rvalid = 1'b0; d_rdata = '0;

        // Clock enable low holds all state.
        cke = 1'b0;
        drive(32'h900, 32'h99, 4'hF);
        step(); step();
        #1;
        check("cke_no_push", level, 0);
        cke = 1'b1;
        #1;
        check("cke_u_ready", u_ready, 1);
        step(); idle_req();
        #1;
        check("cke_level1", level, 1);
        check("cke_d_addr", d_addr, 32'h900);
        cke = 1'b0; d_ready = 1'b1;
        step(); #1;
        check("cke_hold_level", level, 1);
        cke = 1'b1;
        step(); #1;
        check("cke_drained", level, 0);
        d_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
